// File: rtl/reg_arb_pkg.sv
// rtl/reg_arb_pkg.sv - shared types, default sizes and index helper for reg_bank_arbiter
//
// Contents:
//   arb_state_e  : arbiter FSM state (IDLE, GRANT, LOCK)
//   *_DEF        : default NREQ / DATA_W / NREG / LOCK_MAX
//   rr_next()    : round-robin successor index, wrapping n-1 -> 0
package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    LOCK  = 2'd2
  } arb_state_e;

  localparam int NREQ_DEF     = 4;
  localparam int DATA_W_DEF   = 8;
  localparam int NREG_DEF     = 4;
  localparam int LOCK_MAX_DEF = 8;

  function automatic int rr_next(int idx, int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/dff_bank.sv
// rtl/dff_bank.sv - NREG x DATA_W register bank, one write port, one combinational read port
//
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset (clears every register)
//   we/waddr/wdata : write port, applied at posedge
//   raddr/rdata    : combinational read, no write bypass; out-of-range reads return 0
module dff_bank
  import reg_arb_pkg::*;
#(
  parameter int NREG   = NREG_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [NREG];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if ({1'b0, raddr} < (ADDR_W + 1)'(NREG)) begin
      rdata = mem_q[raddr];
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// rtl/reg_bank_arbiter.sv - round-robin arbitrated write port in front of a DFF register bank
//
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   req/req_addr/req_data : per-requester write request, flattened addr/data
//   lock               : per-requester burst lock (honoured only with ARB_LOCK_EN)
//   gnt                : registered one-hot grant pulse; the gnt cycle is the write cycle
//   busy               : |gnt
//   rd_addr/rd_data    : combinational bank read
// Build option: ARB_LOCK_EN enables the LOCK state and the burst counter.
module reg_bank_arbiter
  import reg_arb_pkg::*;
#(
  parameter int  NREQ     = NREQ_DEF,
  parameter int  DATA_W   = DATA_W_DEF,
  parameter int  NREG     = NREG_DEF,
  parameter int  LOCK_MAX = LOCK_MAX_DEF,
  localparam int ADDR_W   = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  input  logic [NREQ-1:0]        lock,
  output logic [NREQ-1:0]        gnt,
  output logic                   busy,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [DATA_W-1:0]      rd_data
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_e        state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic [NREQ-1:0]   eligible;
  logic [NREQ-1:0]   rot;
  logic              win_found;
  logic [IDX_W-1:0]  win_idx;
  logic              hold_lock;
  logic              bank_we;

`ifdef ARB_LOCK_EN
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
`else
  logic unused_lock;
  assign unused_lock = ^{lock, CNT_W'(LOCK_MAX)};
`endif

  always_comb begin
    gnt_d     = '0;
    ptr_d     = ptr_q;
    state_d   = IDLE;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    win_found = 1'b0;
    win_idx   = '0;
    hold_lock = 1'b0;
    // Last cycle's grant masks its requester so a req not yet dropped is not regranted.
    eligible  = req & ~gnt_q;
    // Rotate so bit 0 is the pointer position; lowest set bit is then the RR winner.
    rot       = NREQ'({eligible, eligible} >> ptr_q);
`ifdef ARB_LOCK_EN
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    hold_lock  = (state_q == LOCK) && (lock_cnt_q < CNT_W'(LOCK_MAX))
               && req[owner_q] && lock[owner_q];
`endif
    if (hold_lock) begin
      // Locked owner bypasses its mask; pointer stays frozen for the burst.
      win_found = 1'b1;
      state_d   = LOCK;
`ifdef ARB_LOCK_EN
      win_idx    = owner_q;
      lock_cnt_d = lock_cnt_q + 1'b1;
`endif
    end else begin
      // Scan from far to near so the nearest eligible offset is the final assignment.
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (rot[i]) begin
          win_found = 1'b1;
          win_idx   = IDX_W'((int'(ptr_q) + i) % NREQ);
        end
      end
      if (win_found) begin
        ptr_d   = IDX_W'(rr_next(int'(win_idx), NREQ));
        state_d = GRANT;
`ifdef ARB_LOCK_EN
        if (lock[win_idx]) begin
          state_d    = LOCK;
          owner_d    = win_idx;
          lock_cnt_d = CNT_W'(1);
        end
`endif
      end
    end
    if (win_found) begin
      gnt_d = NREQ'(1) << win_idx;
      for (int i = 0; i < NREQ; i++) begin
        if (int'(win_idx) == i) begin
          wr_addr_d = req_addr[i*ADDR_W +: ADDR_W];
          wr_data_d = req_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      ptr_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

`ifdef ARB_LOCK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q    <= '0;
      lock_cnt_q <= '0;
    end else begin
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end
`endif

  // Captured write is committed at the end of the gnt cycle; out-of-range addresses are dropped.
  assign bank_we = (|gnt_q) && ({1'b0, wr_addr_q} < (ADDR_W + 1)'(NREG));

  dff_bank #(
    .NREG   (NREG),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (bank_we),
    .waddr (wr_addr_q),
    .wdata (wr_data_q),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign gnt  = gnt_q;
  assign busy = |gnt_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb/tb_reg_bank_arbiter.sv - self-checking bench for reg_bank_arbiter
module tb_reg_bank_arbiter;

  localparam int NREQ     = 4;
  localparam int DATA_W   = 8;
  localparam int NREG     = 4;
  localparam int ADDR_W   = 2;
  localparam int LOCK_MAX = 8;
`ifdef ARB_LOCK_EN
  localparam bit LOCK_EN  = 1'b1;
`else
  localparam bit LOCK_EN  = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NREQ-1:0]        req;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        lock;
  logic [NREQ-1:0]        gnt;
  logic                   busy;
  logic [ADDR_W-1:0]      rd_addr;
  logic [DATA_W-1:0]      rd_data;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: granted requester (-1 none), pointer, captured write, bank, lock burst.
  int m_gnt;
  int m_ptr;
  int m_waddr;
  int m_wdata;
  int m_bank [NREG];
  bit m_locked;
  int m_owner;
  int m_cnt;

  always #5 clk = ~clk;

  reg_bank_arbiter #(
    .NREQ     (NREQ),
    .DATA_W   (DATA_W),
    .NREG     (NREG),
    .LOCK_MAX (LOCK_MAX)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .lock     (lock),
    .gnt      (gnt),
    .busy     (busy),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_gnt();
    return (m_gnt < 0) ? 32'd0 : (32'd1 << m_gnt);
  endfunction

  // Applies the specification's per-edge rules to the inputs present just before the edge.
  task automatic model_edge();
    int won;
    if (!rst_n) begin
      m_gnt = -1; m_ptr = 0; m_waddr = 0; m_wdata = 0;
      m_locked = 1'b0; m_owner = 0; m_cnt = 0;
      for (int r = 0; r < NREG; r++) m_bank[r] = 0;
      return;
    end
    if (m_gnt >= 0 && m_waddr < NREG) m_bank[m_waddr] = m_wdata;
    won = -1;
    if (m_locked && m_cnt < LOCK_MAX && req[m_owner] && lock[m_owner]) begin
      won = m_owner;
      m_cnt++;
    end else begin
      m_locked = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (m_ptr + k) % NREQ;
        if (won < 0 && req[c] && c != m_gnt) won = c;
      end
      if (won >= 0) begin
        m_ptr = (won + 1) % NREQ;
        if (LOCK_EN && lock[won]) begin
          m_locked = 1'b1;
          m_owner  = won;
          m_cnt    = 1;
        end
      end
    end
    if (won >= 0) begin
      m_waddr = int'(req_addr[won*ADDR_W +: ADDR_W]);
      m_wdata = int'(req_data[won*DATA_W +: DATA_W]);
    end
    m_gnt = won;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("gnt", {28'd0, gnt}, exp_gnt());
    check("busy", {31'd0, busy}, (m_gnt >= 0) ? 32'd1 : 32'd0);
    check("rd_data", {24'd0, rd_data}, m_bank[rd_addr]);
  endtask

  task automatic set_req(input int i, input bit r, input bit l, input int a, input int d);
    req[i]                       = r;
    lock[i]                      = l;
    req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
    req_data[i*DATA_W +: DATA_W] = DATA_W'(d);
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    rst_n    = 1'b0;
    req      = NREQ'($urandom);
    lock     = NREQ'($urandom);
    req_addr = (NREQ*ADDR_W)'($urandom);
    req_data = (NREQ*DATA_W)'($urandom);
    repeat (n) tick();
    rst_n = 1'b1;
    clear_reqs();
  endtask

  task automatic check_bank(input string tag);
    for (int a = 0; a < NREG; a++) begin
      rd_addr = ADDR_W'(a);
      #1;
      check(tag, {24'd0, rd_data}, m_bank[a]);
    end
  endtask

  initial begin
    rst_n = 1'b0; req = '0; lock = '0; req_addr = '0; req_data = '0; rd_addr = '0;
    m_gnt = -1; m_ptr = 0; m_waddr = 0; m_wdata = 0; m_locked = 1'b0; m_owner = 0; m_cnt = 0;
    for (int r = 0; r < NREG; r++) m_bank[r] = 0;

    // Reset with garbage on the request inputs.
    do_reset(2);
    check("rst_gnt", {28'd0, gnt}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    for (int a = 0; a < NREG; a++) begin
      rd_addr = ADDR_W'(a);
      #1;
      check("rst_rd", {24'd0, rd_data}, 32'd0);
    end

    // Single request: requester 2 writes 0xA5 to register 1.
    rd_addr = 2'd1;
    set_req(2, 1'b1, 1'b0, 1, 8'hA5);
    tick();
    check("single_gnt", {28'd0, gnt}, 32'b0100);
    tick();
    set_req(2, 1'b0, 1'b0, 0, 0);
    check("single_gap", {28'd0, gnt}, 32'd0);
    check("single_rd", {24'd0, rd_data}, 32'hA5);
    tick();

    // Full contention from pointer 0: each requester holds until its own gnt.
    do_reset(1);
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, i, 8'h10 + i);
    for (int k = 1; k <= NREQ; k++) begin
      tick();
      check("contend_gnt", {28'd0, gnt}, 32'd1 << (k - 1));
      if (k >= 2) set_req(k - 2, 1'b0, 1'b0, 0, 0);
    end
    tick();
    set_req(NREQ - 1, 1'b0, 1'b0, 0, 0);
    tick();
    for (int a = 0; a < NREG; a++) begin
      rd_addr = ADDR_W'(a);
      #1;
      check("contend_bank", {24'd0, rd_data}, 32'h10 + a);
    end

    // Stale request: requester 1 alone for three cycles.
    do_reset(1);
    set_req(1, 1'b1, 1'b0, 3, 8'h77);
    tick(); check("stale_c1", {28'd0, gnt}, 32'b0010);
    tick(); check("stale_c2", {28'd0, gnt}, 32'b0000);
    tick(); check("stale_c3", {28'd0, gnt}, 32'b0010);
    clear_reqs();
    tick();

    // Lock burst: requester 0 locked with new data each cycle, requester 3 waiting.
    do_reset(1);
    set_req(3, 1'b1, 1'b0, 2, 8'h33);
    for (int k = 1; k <= 10; k++) begin
      int exp_v;
      set_req(0, 1'b1, 1'b1, k % NREG, 8'hC0 + k);
      tick();
      if (LOCK_EN) exp_v = (k <= LOCK_MAX) ? 1 : 8;
      else         exp_v = (k % 2 == 1) ? 1 : 8;
      if (k <= 9) check("lock_seq", {28'd0, gnt}, exp_v);
    end
    clear_reqs();
    tick();
    check_bank("lock_bank");

    // Reset asserted in the gnt cycle: the captured 0x3C must never land.
    do_reset(1);
    rd_addr = 2'd2;
    set_req(1, 1'b1, 1'b0, 2, 8'h3C);
    tick();
    check("midrst_gnt", {28'd0, gnt}, 32'b0010);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    clear_reqs();
    tick();
    check("midrst_rd", {24'd0, rd_data}, 32'd0);
    tick();
    check("midrst_rd2", {24'd0, rd_data}, 32'd0);

    // Randomized traffic against the model.
    do_reset(1);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        set_req(i, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                int'($urandom_range(0, NREG - 1)), int'($urandom_range(0, 255)));
      end
      rd_addr = ADDR_W'($urandom_range(0, NREG - 1));
      if (c % 97 == 96) rst_n = 1'b0;
      else              rst_n = 1'b1;
      tick();
    end
    rst_n = 1'b1;
    clear_reqs();
    tick();
    tick();
    check_bank("rand_bank");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
